// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and default widths for the ALU sharing controller.
//   alu_cmd_t    : ALU command encodings (other codes pass through untouched)
//   ctrl_state_t : controller FSM states
//   ALU_DW/ALU_CW: default data and command widths
package alu_share_ctrl_pkg;

  localparam int ALU_DW = 9;
  localparam int ALU_CW = 3;

  typedef enum logic [ALU_CW-1:0] {
    CMD_ADD = 3'b000,
    CMD_LSL = 3'b001,
    CMD_XOR = 3'b011,
    CMD_RSR = 3'b101,
    CMD_SUB = 3'b110,
    CMD_CMP = 3'b111
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the requesters and the ALU sharing controller.
//   req_valid/req_ready : per-requester op handshake (ready is a one-hot grant)
//   req_cmd/req_a/req_b : packed per-requester command and operands, slice i = [i*W +: W]
//   rsp_valid/rsp_ready : per-requester response handshake (valid is one-hot)
//   rsp_rslt/rsp_flag   : shared response data, meaningful while any rsp_valid
//   rsp_id              : index of the requester owning the current response
// master = requester side, slave = controller side.
interface alu_share_ctrl_if #(
  parameter int NREQ = 2,
  parameter int DW   = 9,
  parameter int CW   = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*CW-1:0] req_cmd;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [DW-1:0]      rsp_rslt;
  logic               rsp_flag;
  logic [IW-1:0]      rsp_id;

  modport master (
    output req_valid, req_cmd, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_rslt, rsp_flag, rsp_id
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_rslt, rsp_flag, rsp_id
  );
endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : request vector
//   ptr_i   : index of the last winner; search starts at ptr_i+1 and wraps
//   grant_o : one-hot grant (zero when no request)
//   idx_o   : index of the granted requester
//   any_o   : at least one request present
module alu_share_ctrl_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    // Walk the requesters starting just after the last winner; first hit wins.
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        idx_o        = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU among NREQ requesters.
// An IDLE/EXEC/HOLD FSM accepts one round-robin granted op, registers its
// command and operands into the ALU, captures the ALU result one cycle later
// and holds it as a response until the owning requester accepts it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus                 : request/response bundle (slave side)
//   alu_cmd/inA/inB     : registered command and operands to the ALU
//   alu_rslt/alu_flag   : combinational ALU result
//   busy                : high while an op is in EXEC or HOLD
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = ALU_DW,
  parameter int CW   = ALU_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_share_ctrl_if.slave bus,
  output logic [CW-1:0] alu_cmd,
  output logic [DW-1:0] alu_inA,
  output logic [DW-1:0] alu_inB,
  input  logic [DW-1:0] alu_rslt,
  input  logic          alu_flag,
  output logic          busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  ctrl_state_t     state_q;
  logic [IW-1:0]   ptr_q;
  logic [CW-1:0]   alu_cmd_q;
  logic [DW-1:0]   alu_a_q;
  logic [DW-1:0]   alu_b_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_rslt_q;
  logic            rsp_flag_q;
  logic [IW-1:0]   rsp_id_q;
  logic            busy_q;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;

  alu_share_ctrl_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (gnt),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  // Grant is only exposed while IDLE, so nothing is accepted during the
  // response handshake cycle.
  assign bus.req_ready = (state_q == IDLE) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NREQ - 1);
      alu_cmd_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rslt_q  <= '0;
      rsp_flag_q  <= 1'b0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            alu_cmd_q <= bus.req_cmd[int'(gnt_idx)*CW +: CW];
            alu_a_q   <= bus.req_a[int'(gnt_idx)*DW +: DW];
            alu_b_q   <= bus.req_b[int'(gnt_idx)*DW +: DW];
            rsp_id_q  <= gnt_idx;
            ptr_q     <= gnt_idx;
            busy_q    <= 1'b1;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          rsp_rslt_q  <= alu_rslt;
          rsp_flag_q  <= alu_flag;
          rsp_valid_q <= NREQ'(1) << rsp_id_q;
          state_q     <= HOLD;
        end
        HOLD: begin
          // Only the owner's ready bit completes the response.
          if (bus.rsp_ready[rsp_id_q]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign alu_cmd      = alu_cmd_q;
  assign alu_inA      = alu_a_q;
  assign alu_inB      = alu_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rslt  = rsp_rslt_q;
  assign bus.rsp_flag  = rsp_flag_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = busy_q;

endmodule
